rx_correlator_mac: RTL

//  Receive-chain stage directly downstream of the circular sample BRAM.

---
 rtl/rx_correlator_mac.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rx_correlator_mac.sv
// rx_correlator_mac
// Sits after the circular sample BRAM. Each accepted start runs one sweep
// over MEMORY_LENGTH samples, oldest first. Each sample is multiplied by a
// +/-1 chip from an external code ROM, and the products are summed. The
// sum is emitted as a one-cycle corr_valid pulse.
// Optional feature macro: RX_CORR_PEAK_EN. When it is defined, the block
// tracks the peak |corr_out|, the sweep index of that peak, and a clear
// input.
// RD_LATENCY must be at least 1. code_addr is 9 bits wide, so
// MEMORY_LENGTH must not exceed 512.
module rx_correlator_mac #(
  parameter int MEMORY_LENGTH = 510,
  parameter int RD_LATENCY    = 2,
  parameter int ACC_W         = 26
) (
  input  logic                    crx_clk,
  input  logic                    rrx_rst,
  input  logic                    erx_en,
  input  logic                    start,
  input  logic signed [15:0]      data_in,
  output logic [8:0]              code_addr,
  input  logic                    code_bit,
  output logic signed [ACC_W-1:0] corr_out,
  output logic                    corr_valid,
  output logic                    busy,
  output logic                    overrun
`ifdef RX_CORR_PEAK_EN
  ,
  input  logic                    peak_clr,
  output logic [ACC_W-1:0]        peak_val,
  output logic [15:0]             peak_idx
`endif
);

  localparam int CNT_W    = (MEMORY_LENGTH > 1) ? $clog2(MEMORY_LENGTH) : 1;
  localparam int LAT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int LAT_LAST = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;

  localparam logic [CNT_W-1:0] SMP_LAST   = CNT_W'(MEMORY_LENGTH - 1);
  localparam logic [LAT_W-1:0] LAT_END    = LAT_W'(LAT_LAST);
  localparam logic [8:0]       ADDR_LAST  = 9'(MEMORY_LENGTH - 1);
  localparam logic [8:0]       ADDR_FIRST = (MEMORY_LENGTH > 1) ? 9'd1 : 9'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic [CNT_W-1:0]        r_smp_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_corr_out;
  logic                    r_corr_valid;
  logic                    r_busy;
  logic                    r_overrun;
  logic [8:0]              r_code_addr;

  logic                    w_start_acc;
  logic signed [ACC_W-1:0] w_sample;
  logic signed [ACC_W-1:0] w_acc_next;

  // A start is only seen on enabled cycles. A start during a freeze is dropped.
  assign w_start_acc = start & erx_en;

  // Sign-extend the sample to the full accumulator width.
  assign w_sample = {{(ACC_W-16){data_in[15]}}, data_in};

  // A chip value of 1 adds the sample, and a chip value of 0 subtracts it.
  assign w_acc_next = code_bit ? (r_acc + w_sample) : (r_acc - w_sample);

  // The address for chip 0 must go out in the start cycle itself, so that
  // chip 0 and sample 0 arrive together RD_LATENCY cycles later. The
  // registered counter already holds the lookahead address for chip 1.
  assign code_addr = w_start_acc ? 9'd0 : r_code_addr;

  // Code address lookahead. On a start it loads chip 1. Then it steps once
  // per enabled cycle until it wraps to 0, and it parks at 0 until the
  // next start.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      r_code_addr <= 9'd0;
    end else if (erx_en) begin
      if (start) begin
        r_code_addr <= ADDR_FIRST;
      end else if (r_code_addr != 9'd0) begin
        r_code_addr <= (r_code_addr == ADDR_LAST) ? 9'd0 : (r_code_addr + 9'd1);
      end
    end
  end

  // Sweep sequencer: wait for the read pipeline, accumulate, publish, and go idle.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_smp_cnt    <= '0;
      r_acc        <= '0;
      r_corr_out   <= '0;
      r_corr_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (erx_en) begin
      r_corr_valid <= 1'b0;
      if (start) begin
        // A start in WAIT or ACCUM aborts the running sweep. A start in
        // DONE is legal, because that sweep has already produced its
        // result.
        if ((r_state == S_WAIT) || (r_state == S_ACCUM)) begin
          r_overrun <= 1'b1;
        end
        r_acc     <= '0;
        r_lat_cnt <= '0;
        r_smp_cnt <= '0;
        r_busy    <= 1'b1;
        r_state   <= (RD_LATENCY > 1) ? S_WAIT : S_ACCUM;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_WAIT: begin
            // The start cycle is latency cycle 0, and WAIT covers the
            // cycles after it until data_in is valid.
            if (r_lat_cnt == LAT_END) begin
              r_state <= S_ACCUM;
            end else begin
              r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
          end
          S_ACCUM: begin
            r_acc <= w_acc_next;
            if (r_smp_cnt == SMP_LAST) begin
              // Publish as the last product lands. The pulse then
              // coincides with the DONE cycle.
              r_corr_out   <= w_acc_next;
              r_corr_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_smp_cnt <= r_smp_cnt + CNT_W'(1);
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign corr_out   = r_corr_out;
  assign corr_valid = r_corr_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

`ifdef RX_CORR_PEAK_EN
  logic [ACC_W-1:0] r_peak_val;
  logic [15:0]      r_peak_idx;
  logic [15:0]      r_sweep_cnt;
  logic [ACC_W-1:0] w_corr_abs;

  // Magnitude of the published result. The headroom in ACC_W keeps the
  // most negative value out of reach, so negation cannot overflow.
  assign w_corr_abs = r_corr_out[ACC_W-1] ? (-r_corr_out) : r_corr_out;

  // Peak tracker. It acts once per pulse, on the enabled cycle where
  // corr_valid is high. A clear takes priority over an update.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      r_peak_val  <= '0;
      r_peak_idx  <= '0;
      r_sweep_cnt <= '0;
    end else if (erx_en) begin
      if (peak_clr) begin
        r_peak_val  <= '0;
        r_peak_idx  <= '0;
        r_sweep_cnt <= '0;
      end else if (r_corr_valid) begin
        r_sweep_cnt <= r_sweep_cnt + 16'd1;
        if (w_corr_abs > r_peak_val) begin
          r_peak_val <= w_corr_abs;
          r_peak_idx <= r_sweep_cnt;
        end
      end
    end
  end

  assign peak_val = r_peak_val;
  assign peak_idx = r_peak_idx;
`endif

endmodule
